// File: rtl/iterative_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// iterative_magnitude_comparator
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are compared DIGIT
// bits per cycle, most significant digit first. The scan stops at the first
// digit that differs. Unsigned or two's-complement ordering is chosen per
// transaction.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. A producer holds valid and its payload
// steady until that edge. in_ready is high only in IDLE and never while rst is
// asserted. out_valid stays high, with the result held steady, until the
// consumer raises out_ready. No combinational path runs from in_valid to
// out_valid, and out_ready only steers the next state.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     a, b and signed_mode are valid
//   in_ready     block can accept a new transaction (IDLE only)
//   a, b         operands
//   signed_mode  1 = two's-complement compare, 0 = unsigned
//   out_valid    result flags and digits_used are valid
//   out_ready    consumer accepts the result
//   a_gt_b       A > B
//   a_eq_b       A = B
//   a_lt_b       A < B
//   digits_used  digits examined before the decision (1..NDIG)
//   busy         high in COMPARE or DONE
//   state_dbg    current FSM state (IDLE=0, COMPARE=1, DONE=2) for checkers
// ---------------------------------------------------------------------------
module iterative_magnitude_comparator #(
  parameter  int WIDTH = 16,
  parameter  int DIGIT = 4,
  localparam int NDIG  = WIDTH / DIGIT,
  localparam int CW    = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic [CW-1:0]    digits_used,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic [WIDTH-1:0] sign_flip;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [CW-1:0]    used_now;

  // Inverting the sign bit maps two's-complement onto offset binary, so a
  // plain unsigned digit compare orders signed operands correctly. The flip
  // is applied once at capture, so the scan itself is mode-agnostic.
  assign sign_flip = signed_mode ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  assign dig_a    = a_r[idx*DIGIT +: DIGIT];
  assign dig_b    = b_r[idx*DIGIT +: DIGIT];
  // Digits examined so far, including the current one: NDIG - idx.
  assign used_now = CW'(NDIG) - CW'(idx);

  assign in_ready  = (state == IDLE) && !rst;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      out_valid   <= 1'b0;
      a_gt_b      <= 1'b0;
      a_eq_b      <= 1'b0;
      a_lt_b      <= 1'b0;
      digits_used <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a ^ sign_flip;
            b_r   <= b ^ sign_flip;
            idx   <= IW'(NDIG - 1);
            busy  <= 1'b1;
            state <= COMPARE;
          end
        end

        COMPARE: begin
          if (dig_a != dig_b) begin
            a_gt_b      <= (dig_a > dig_b);
            a_lt_b      <= (dig_a < dig_b);
            digits_used <= used_now;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else if (idx == '0) begin
            a_eq_b      <= 1'b1;
            digits_used <= used_now;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end

        DONE: begin
          // digits_used deliberately keeps its last value after the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            a_gt_b    <= 1'b0;
            a_eq_b    <= 1'b0;
            a_lt_b    <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          a_gt_b    <= 1'b0;
          a_eq_b    <= 1'b0;
          a_lt_b    <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// Bench for iterative_magnitude_comparator. Three instances (DIGIT = 4, 1, 16,
// WIDTH = 16) share operand inputs and out_ready; each has its own in_valid.
// Instance 0 (DIGIT = 4) carries the directed scenarios; all three take the
// randomised run against a reference built from plain integer comparison and
// the position of the highest differing bit.
// ---------------------------------------------------------------------------
module tb_iterative_magnitude_comparator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]      iv;
  logic [15:0]     a;
  logic [15:0]     b;
  logic            sm;
  logic            out_ready;
  logic [2:0]      ir;
  logic [2:0]      ov;
  logic [2:0]      gt;
  logic [2:0]      eq;
  logic [2:0]      lt;
  logic [2:0]      bs;
  logic [2:0][4:0] du;
  logic [2:0][1:0] st;

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG  = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    localparam int DCW = $clog2(16 / DG + 1);
    logic [DCW-1:0] du_l;
    iterative_magnitude_comparator #(.WIDTH(16), .DIGIT(DG)) u_dut (
      .clk(clk),
      .rst(rst),
      .in_valid(iv[g]),
      .in_ready(ir[g]),
      .a(a),
      .b(b),
      .signed_mode(sm),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .a_gt_b(gt[g]),
      .a_eq_b(eq[g]),
      .a_lt_b(lt[g]),
      .digits_used(du_l),
      .busy(bs[g]),
      .state_dbg(st[g])
    );
    assign du[g] = 5'(du_l);
  end

  function automatic int digit_of(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 1 : 16);
  endfunction

  // ---------------- reference model ----------------
  // f = {gt, eq, lt}; du = digits from the MSB up to and including the first
  // differing one (all of them when equal).
  function automatic void ref_cmp(input logic [15:0] aa, input logic [15:0] bb,
                                  input logic s, input int dg,
                                  output logic [2:0] f, output int edu);
    logic [15:0] x;
    int p;
    if (s) f = {($signed(aa) > $signed(bb)), (aa == bb), ($signed(aa) < $signed(bb))};
    else   f = {(aa > bb), (aa == bb), (aa < bb)};
    x = aa ^ bb;
    if (x == 16'h0) begin
      edu = 16 / dg;
    end else begin
      p = 15;
      while (x[p] == 1'b0) p--;
      edu = 16 / dg - p / dg;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accept edge with
  // the operand inputs scrambled so only captured copies can matter.
  task automatic start_txn(input int g, input logic [15:0] aa, input logic [15:0] bb,
                           input logic s);
    int n;
    n = 0;
    a = aa; b = bb; sm = s; iv[g] = 1'b1;
    while (ir[g] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (ir[g] !== 1'b1) begin
      n_err++;
      $display("FAIL accept_timeout dut%0d: in_ready=%b required 1", g, ir[g]);
    end
    @(posedge clk);
    @(negedge clk);
    iv[g] = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sm = 1'($urandom);
  endtask

  // Counts rising edges from the accept edge until out_valid is seen.
  task automatic wait_result(input int g, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (ov[g] !== 1'b1 && lat < 40);
    n_cmp++;
    if (ov[g] !== 1'b1) begin
      n_err++;
      $display("FAIL result_timeout dut%0d: out_valid=%b required 1", g, ov[g]);
    end
  endtask

  task automatic release_result(input int g);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({ov[g], gt[g], eq[g], lt[g]} !== 4'b0000) begin
      n_err++;
      $display("FAIL release dut%0d: valid/flags=%b required 0000", g, {ov[g], gt[g], eq[g], lt[g]});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; iv = 3'b111; out_ready = 1'b0;
    a = 16'h1234; b = 16'h4321; sm = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if ({ir[g], ov[g], gt[g], eq[g], lt[g], bs[g], du[g]} !== 11'b0) begin
        n_err++;
        $display("FAIL reset_values dut%0d: rdy,val,gt,eq,lt,busy,du=%b required 0",
                 g, {ir[g], ov[g], gt[g], eq[g], lt[g], bs[g], du[g]});
      end
    end
    iv = 3'b000;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if ({ir[g], bs[g]} !== 2'b10) begin
        n_err++;
        $display("FAIL reset_exit dut%0d: in_ready,busy=%b required 10", g, {ir[g], bs[g]});
      end
    end
  endtask

  task automatic test_early_exit();
    int lat;
    start_txn(0, 16'h5A00, 16'h3A00, 1'b0);
    wait_result(0, lat);
    n_cmp++;
    if ({gt[0], eq[0], lt[0], du[0], lat[4:0]} !== {3'b100, 5'd1, 5'd1}) begin
      n_err++;
      $display("FAIL early_exit: flags=%b du=%0d lat=%0d required flags=100 du=1 lat=1",
               {gt[0], eq[0], lt[0]}, du[0], lat);
    end
    n_cmp++;
    if ({ir[0], bs[0]} !== 2'b01) begin
      n_err++;
      $display("FAIL done_status: in_ready,busy=%b required 01", {ir[0], bs[0]});
    end
    release_result(0);
  endtask

  task automatic test_full_scan();
    int lat;
    start_txn(0, 16'h1234, 16'h1234, 1'b0);
    wait_result(0, lat);
    n_cmp++;
    if ({gt[0], eq[0], lt[0], du[0], lat[4:0]} !== {3'b010, 5'd4, 5'd4}) begin
      n_err++;
      $display("FAIL full_scan_eq: flags=%b du=%0d lat=%0d required flags=010 du=4 lat=4",
               {gt[0], eq[0], lt[0]}, du[0], lat);
    end
    release_result(0);
    start_txn(0, 16'h1235, 16'h1234, 1'b0);
    wait_result(0, lat);
    n_cmp++;
    if ({gt[0], eq[0], lt[0], du[0], lat[4:0]} !== {3'b100, 5'd4, 5'd4}) begin
      n_err++;
      $display("FAIL full_scan_gt: flags=%b du=%0d lat=%0d required flags=100 du=4 lat=4",
               {gt[0], eq[0], lt[0]}, du[0], lat);
    end
    release_result(0);
  endtask

  task automatic test_signed();
    int lat;
    start_txn(0, 16'hFFFF, 16'h0001, 1'b1);
    wait_result(0, lat);
    n_cmp++;
    if ({gt[0], eq[0], lt[0], du[0]} !== {3'b001, 5'd1}) begin
      n_err++;
      $display("FAIL signed_neg: flags=%b du=%0d required flags=001 du=1", {gt[0], eq[0], lt[0]}, du[0]);
    end
    release_result(0);
    start_txn(0, 16'hFFFF, 16'h0001, 1'b0);
    wait_result(0, lat);
    n_cmp++;
    if ({gt[0], eq[0], lt[0], du[0]} !== {3'b100, 5'd1}) begin
      n_err++;
      $display("FAIL unsigned_big: flags=%b du=%0d required flags=100 du=1", {gt[0], eq[0], lt[0]}, du[0]);
    end
    release_result(0);
    start_txn(0, 16'h8000, 16'h8000, 1'b1);
    wait_result(0, lat);
    n_cmp++;
    if ({gt[0], eq[0], lt[0], du[0]} !== {3'b010, 5'd4}) begin
      n_err++;
      $display("FAIL signed_min_eq: flags=%b du=%0d required flags=010 du=4", {gt[0], eq[0], lt[0]}, du[0]);
    end
    release_result(0);
  endtask

  task automatic test_backpressure();
    int lat;
    // 00A0 vs 00B0: third digit decides, A < B.
    start_txn(0, 16'h00A0, 16'h00B0, 1'b0);
    wait_result(0, lat);
    a = 16'h7000; b = 16'h1000; sm = 1'b0; iv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ov[0], ir[0], bs[0], gt[0], eq[0], lt[0], du[0]} !== {3'b101, 3'b001, 5'd3}) begin
        n_err++;
        $display("FAIL hold_cycle%0d: val,rdy,busy=%b flags=%b du=%0d required 101 001 3",
                 i, {ov[0], ir[0], bs[0]}, {gt[0], eq[0], lt[0]}, du[0]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({ov[0], ir[0], bs[0], gt[0], eq[0], lt[0], du[0]} !== {3'b010, 3'b000, 5'd3}) begin
      n_err++;
      $display("FAIL after_release: val,rdy,busy=%b flags=%b du=%0d required 010 000 3",
               {ov[0], ir[0], bs[0]}, {gt[0], eq[0], lt[0]}, du[0]);
    end
    start_txn(0, 16'h7000, 16'h1000, 1'b0);
    n_cmp++;
    if (bs[0] !== 1'b1) begin
      n_err++;
      $display("FAIL pending_accept: busy=%b required 1", bs[0]);
    end
    wait_result(0, lat);
    n_cmp++;
    if ({gt[0], eq[0], lt[0], du[0], lat[4:0]} !== {3'b100, 5'd1, 5'd1}) begin
      n_err++;
      $display("FAIL pending_result: flags=%b du=%0d lat=%0d required flags=100 du=1 lat=1",
               {gt[0], eq[0], lt[0]}, du[0], lat);
    end
    release_result(0);
  endtask

  task automatic test_reset_mid();
    int lat;
    start_txn(0, 16'h1234, 16'h1234, 1'b0);
    @(posedge clk);          // first compare edge
    @(negedge clk);
    rst = 1'b1;              // applied on the second compare edge
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ov[0], gt[0], eq[0], lt[0], bs[0], ir[0]} !== 6'b0) begin
      n_err++;
      $display("FAIL mid_reset: val,gt,eq,lt,busy,rdy=%b required 000000",
               {ov[0], gt[0], eq[0], lt[0], bs[0], ir[0]});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ir[0] !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_ready: in_ready=%b required 1", ir[0]);
    end
    // 00FF vs 0100: second digit decides, A < B.
    start_txn(0, 16'h00FF, 16'h0100, 1'b0);
    wait_result(0, lat);
    n_cmp++;
    if ({gt[0], eq[0], lt[0], du[0], lat[4:0]} !== {3'b001, 5'd2, 5'd2}) begin
      n_err++;
      $display("FAIL post_reset_txn: flags=%b du=%0d lat=%0d required flags=001 du=2 lat=2",
               {gt[0], eq[0], lt[0]}, du[0], lat);
    end
    release_result(0);
  endtask

  task automatic test_random();
    logic [15:0] aa;
    logic [15:0] bb;
    logic        s;
    logic [2:0]  ef;
    int          edu;
    int          lat;
    for (int g = 0; g < 3; g++) begin
      for (int n = 0; n < 334; n++) begin
        aa = 16'($urandom);
        case ($urandom_range(0, 3))
          0:       bb = aa;
          1:       bb = aa ^ (16'h1 << $urandom_range(0, 15));
          2:       bb = {aa[15:8], 8'($urandom)};
          default: bb = 16'($urandom);
        endcase
        s = 1'($urandom_range(0, 1));
        ref_cmp(aa, bb, s, digit_of(g), ef, edu);
        start_txn(g, aa, bb, s);
        wait_result(g, lat);
        n_cmp++;
        if ({gt[g], eq[g], lt[g]} !== ef) begin
          n_err++;
          $display("FAIL rand_flags dut%0d a=%h b=%h s=%b: flags=%b required %b",
                   g, aa, bb, s, {gt[g], eq[g], lt[g]}, ef);
        end
        n_cmp++;
        if (int'(du[g]) != edu || lat != edu) begin
          n_err++;
          $display("FAIL rand_digits dut%0d a=%h b=%h: du=%0d lat=%0d required %0d",
                   g, aa, bb, du[g], lat, edu);
        end
        release_result(g);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_early_exit();
    test_full_scan();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
